// File: rtl/wb_byte_master.sv
// wb_byte_master: byte-addressed request port to a 16-bit Wishbone classic initiator with split word cycles and ack timeout
module wb_byte_master #(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic        req_byte_i,
  input  logic [19:0] req_adr_i,
  input  logic [15:0] req_dat_i,
  output logic [15:0] req_dat_o,
  output logic        req_done_o,
  output logic        req_err_o,
  output logic        busy_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [19:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);
  typedef enum logic [2:0] {IDLE, CYC1, GAP, CYC2, DONE} state_t;
  state_t state, nxt;
  logic byte_q;
  logic [19:0] adr_q;
  logic [7:0] dat_hi;
  logic [15:0] res, res_n, wdat_n, rdat_n;
  logic [TO_W-1:0] cnt;
  logic [19:0] wadr_n;
  logic [1:0] sel_n;
  logic split, in_cyc, acked, tmo, ent1, ent2, cyc_n;
  assign split = ~byte_q & adr_q[0];
  assign in_cyc = state == CYC1 || state == CYC2;
  assign acked = in_cyc & wb_ack_i;
  assign tmo = in_cyc & ~wb_ack_i & (cnt == TO_W'(TIMEOUT - 1));
  assign ent1 = state == IDLE && req_i;
  assign ent2 = state == GAP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_i ? CYC1 : IDLE;
      CYC1:    nxt = wb_ack_i ? (split ? GAP : DONE) : (tmo ? DONE : CYC1);
      GAP:     nxt = CYC2;
      CYC2:    nxt = (wb_ack_i || tmo) ? DONE : CYC2;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign cyc_n = nxt == CYC1 || nxt == CYC2;
  // a split word takes its low byte from the high lane of CYC1 and its high byte from the low lane of CYC2
  assign res_n = !acked ? res :
                 state == CYC2 ? {wb_dat_i[7:0], res[7:0]} :
                 byte_q ? {8'h00, adr_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]} :
                 split ? {res[15:8], wb_dat_i[15:8]} : wb_dat_i;
  assign wadr_n = ent1 ? {1'b0, req_adr_i[19:1]} :
                  ent2 ? {1'b0, adr_q[19:1] + 19'd1} : wb_adr_o;
  assign sel_n = ent1 ? (req_adr_i[0] ? 2'b10 : (req_byte_i ? 2'b01 : 2'b11)) :
                 ent2 ? 2'b01 : wb_sel_o;
  assign wdat_n = ent1 ? (req_byte_i ? {2{req_dat_i[7:0]}} :
                          req_adr_i[0] ? {req_dat_i[7:0], 8'h00} : req_dat_i) :
                  ent2 ? {8'h00, dat_hi} : wb_dat_o;
  assign rdat_n = nxt == DONE ? (tmo ? 16'hFFFF : res_n) : req_dat_o;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      byte_q     <= 1'b0;
      adr_q      <= '0;
      dat_hi     <= '0;
      res        <= '0;
      cnt        <= '0;
      req_dat_o  <= '0;
      req_done_o <= 1'b0;
      req_err_o  <= 1'b0;
      busy_o     <= 1'b0;
      wb_dat_o   <= '0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
    end else begin
      if (ent1) begin
        byte_q  <= req_byte_i;
        adr_q   <= req_adr_i;
        dat_hi  <= req_dat_i[15:8];
        wb_we_o <= req_we_i;
      end
      cnt        <= in_cyc ? cnt + TO_W'(1) : '0;
      res        <= res_n;
      req_dat_o  <= rdat_n;
      req_done_o <= nxt == DONE;
      req_err_o  <= tmo;
      busy_o     <= nxt != IDLE;
      wb_dat_o   <= wdat_n;
      wb_adr_o   <= wadr_n;
      wb_sel_o   <= sel_n;
      wb_cyc_o   <= cyc_n;
      wb_stb_o   <= cyc_n;
    end
endmodule

// File: tb/tb_wb_byte_master.sv
// tb_wb_byte_master: directed and randomized checks of wb_byte_master against a byte-addressed memory model
module tb_wb_byte_master;
  localparam int TO = 4;
  typedef struct {
    logic [19:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] dat;
    int          w;
  } bus_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req = 1'b0, req_we = 1'b0, req_byte = 1'b0;
  logic [19:0] req_adr = '0;
  logic [15:0] req_dat = '0;
  logic [15:0] rdat;
  logic done, err, busy;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic [19:0] wb_adr;
  logic [1:0] wb_sel;
  logic wb_we, wb_cyc, wb_stb;
  logic wb_ack = 1'b0;
  int vectors = 0, miscompares = 0;
  int force_wait = 0, cyc_hi = 0, cur_w = 0, wc = 0;
  logic prev_cyc = 1'b0;
  bus_t log_q[$], exp_q[$];
  bus_t sc;
  logic [7:0] mem_s [int];
  logic [7:0] mem_r [int];

  always #5 clk = ~clk;

  wb_byte_master #(.TIMEOUT(TO), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_i(req), .req_we_i(req_we), .req_byte_i(req_byte), .req_adr_i(req_adr), .req_dat_i(req_dat),
    .req_dat_o(rdat), .req_done_o(done), .req_err_o(err), .busy_o(busy),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_adr_o(wb_adr), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [7:0] rd_s(input int a);
    return mem_s.exists(a) ? mem_s[a] : dflt(a);
  endfunction

  function automatic logic [7:0] rd_r(input int a);
    return mem_r.exists(a) ? mem_r[a] : dflt(a);
  endfunction

  task automatic set_b(input int a, input logic [7:0] v);
    mem_s[a] = v;
    mem_r[a] = v;
  endtask

  // slave: acks after cur_w wait cycles, serves/stores bytes in its own memory, logs each bus cycle
  always @(posedge clk) begin
    #1;
    if (!wb_cyc) wb_ack = 1'b0;
    else begin
      if (!prev_cyc) begin
        cur_w = force_wait >= 0 ? force_wait : int'($urandom_range(0, 2));
        wc = 0;
        sc.adr = wb_adr;
        sc.sel = wb_sel;
        sc.we = wb_we;
        sc.dat = wb_dat_o;
        sc.w = cur_w;
        log_q.push_back(sc);
      end
      cyc_hi++;
      chk("stb_eq_cyc", wb_stb, wb_cyc);
      wb_ack = wc == cur_w;
      if (wb_ack) begin
        wb_dat_i = {rd_s(int'({wb_adr[18:0], 1'b1})), rd_s(int'({wb_adr[18:0], 1'b0}))};
        if (wb_we && wb_sel[0]) mem_s[int'({wb_adr[18:0], 1'b0})] = wb_dat_o[7:0];
        if (wb_we && wb_sel[1]) mem_s[int'({wb_adr[18:0], 1'b1})] = wb_dat_o[15:8];
      end
      wc++;
    end
    prev_cyc = wb_cyc;
  end

  // reference: a request touches byte adr (and adr+1 mod 2^20 for words); one bus cycle per word touched
  task automatic model_req(input logic we, input logic b, input logic [19:0] a, input logic [15:0] d,
                           output logic [15:0] er);
    logic [19:0] a1;
    bus_t c;
    a1 = a + 20'd1;
    exp_q.delete();
    er = b ? {8'h00, rd_r(int'(a))} : {rd_r(int'(a1)), rd_r(int'(a))};
    c.we = we;
    c.w = 0;
    c.adr = {1'b0, a[19:1]};
    if (b) begin
      c.sel = a[0] ? 2'b10 : 2'b01;
      c.dat = {d[7:0], d[7:0]};
      exp_q.push_back(c);
    end else if (!a[0]) begin
      c.sel = 2'b11;
      c.dat = d;
      exp_q.push_back(c);
    end else begin
      c.sel = 2'b10;
      c.dat = {d[7:0], 8'h00};
      exp_q.push_back(c);
      c.adr = {1'b0, a1[19:1]};
      c.sel = 2'b01;
      c.dat = {8'h00, d[15:8]};
      exp_q.push_back(c);
    end
    if (we) begin
      mem_r[int'(a)] = d[7:0];
      if (!b) mem_r[int'(a1)] = d[15:8];
    end
  endtask

  task automatic run_req(input logic we, input logic b, input logic [19:0] a, input logic [15:0] d,
                         input int pulse_at, output int lat, output logic [15:0] r, output logic e);
    @(negedge clk);
    log_q.delete();
    cyc_hi = 0;
    req_we = we;
    req_byte = b;
    req_adr = a;
    req_dat = d;
    req = 1'b1;
    lat = 0;
    r = '0;
    e = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      req = lat == pulse_at;
      chk("busy", busy, 1);
      if (!done) chk("err_without_done", err, 0);
      else begin
        r = rdat;
        e = err;
      end
    end while (!done && lat < 40);
    chk("done_seen", done, 1);
    req = 1'b0;
  endtask

  task automatic chk_cyc(input string t, input int i, input logic [19:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat);
    if (log_q.size() > i) begin
      chk({t, "_adr"}, log_q[i].adr, adr);
      chk({t, "_sel"}, log_q[i].sel, sel);
      chk({t, "_wdat"}, log_q[i].dat, dat);
    end else chk({t, "_present"}, log_q.size(), i + 1);
  endtask

  task automatic check_resp(input string t, input logic we, input int lat, input logic [15:0] r,
                            input logic e, input logic [15:0] er);
    int el;
    el = log_q.size();
    foreach (log_q[i]) el += log_q[i].w + 1;
    chk({t, "_lat"}, lat, el);
    chk({t, "_err"}, e, 0);
    if (!we) chk({t, "_rdat"}, r, er);
    chk({t, "_ncyc"}, log_q.size(), exp_q.size());
    if (log_q.size() == exp_q.size())
      foreach (exp_q[i]) begin
        chk({t, "_we"}, log_q[i].we, exp_q[i].we);
        chk_cyc(t, i, exp_q[i].adr, exp_q[i].sel, exp_q[i].dat);
      end
  endtask

  initial begin
    int lat, dc;
    logic [15:0] r, er, d;
    logic e, w, b;
    logic [19:0] a;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdat", rdat, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_wdat", wb_dat_o, 0);
    chk("rst_we", wb_we, 0);
    rst_n = 1'b1;

    force_wait = 0;
    set_b(32'h400, 8'hEF);
    set_b(32'h401, 8'hBE);
    model_req(1'b0, 1'b0, 20'h00400, 16'h0000, er);
    run_req(1'b0, 1'b0, 20'h00400, 16'h0000, -1, lat, r, e);
    check_resp("rd16", 1'b0, lat, r, e, er);
    chk("rd16_lat2", lat, 2);
    chk("rd16_beef", r, 16'hBEEF);
    chk_cyc("rd16_c0", 0, 20'h00200, 2'b11, 16'h0000);

    model_req(1'b1, 1'b1, 20'h00401, 16'h12A5, er);
    run_req(1'b1, 1'b1, 20'h00401, 16'h12A5, -1, lat, r, e);
    check_resp("wr8", 1'b1, lat, r, e, er);
    chk("wr8_lat2", lat, 2);
    chk_cyc("wr8_c0", 0, 20'h00200, 2'b10, 16'hA5A5);
    @(negedge clk);
    chk("wr8_busy_after", busy, 0);
    chk("wr8_done_after", done, 0);
    chk("wr8_mem_hi", rd_s(32'h401), 8'hA5);
    chk("wr8_mem_lo", rd_s(32'h400), 8'hEF);

    set_b(32'h400, 8'h00);
    set_b(32'h401, 8'h34);
    set_b(32'h402, 8'h12);
    set_b(32'h403, 8'h00);
    model_req(1'b0, 1'b0, 20'h00401, 16'h0000, er);
    run_req(1'b0, 1'b0, 20'h00401, 16'h0000, -1, lat, r, e);
    check_resp("split", 1'b0, lat, r, e, er);
    chk("split_lat4", lat, 4);
    chk("split_1234", r, 16'h1234);
    chk_cyc("split_c0", 0, 20'h00200, 2'b10, 16'h0000);
    chk_cyc("split_c1", 1, 20'h00201, 2'b01, 16'h0000);

    model_req(1'b1, 1'b0, 20'hFFFFF, 16'hCAFE, er);
    run_req(1'b1, 1'b0, 20'hFFFFF, 16'hCAFE, -1, lat, r, e);
    check_resp("wrap", 1'b1, lat, r, e, er);
    chk("wrap_lat4", lat, 4);
    chk_cyc("wrap_c0", 0, 20'h7FFFF, 2'b10, 16'hFE00);
    chk_cyc("wrap_c1", 1, 20'h00000, 2'b01, 16'h00CA);
    chk("wrap_mem_top", rd_s(32'hFFFFF), 8'hFE);
    chk("wrap_mem_zero", rd_s(32'h0), 8'hCA);

    force_wait = 99;
    run_req(1'b0, 1'b0, 20'h00401, 16'h0000, -1, lat, r, e);
    chk("to_lat", lat, 5);
    chk("to_err", e, 1);
    chk("to_rdat", r, 16'hFFFF);
    chk("to_cyc_cycles", cyc_hi, TO);
    chk("to_cyc2_skipped", log_q.size(), 1);

    force_wait = TO - 1;
    model_req(1'b0, 1'b0, 20'h00400, 16'h0000, er);
    run_req(1'b0, 1'b0, 20'h00400, 16'h0000, -1, lat, r, e);
    check_resp("late_ack", 1'b0, lat, r, e, er);
    chk("late_ack_cycles", cyc_hi, TO);

    @(negedge clk);
    log_q.delete();
    req_we = 1'b0;
    req_byte = 1'b0;
    req_adr = 20'h00401;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 30 && log_q.size() < 2; k++) @(negedge clk);
    chk("rst2_reach_cyc2", log_q.size(), 2);
    chk("rst2_busy_pre", busy, 1);
    chk("rst2_cyc_pre", wb_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_cyc", wb_cyc, 0);
    chk("rst2_stb", wb_stb, 0);
    chk("rst2_done", done, 0);
    chk("rst2_err", err, 0);
    chk("rst2_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    cyc_hi = 0;
    repeat (12) begin
      @(negedge clk);
      dc += int'(done);
    end
    chk("rst2_no_done", dc, 0);
    chk("rst2_no_cyc", cyc_hi, 0);

    force_wait = 1;
    model_req(1'b0, 1'b0, 20'h00400, 16'h0000, er);
    run_req(1'b0, 1'b0, 20'h00400, 16'h0000, 2, lat, r, e);
    check_resp("pulse", 1'b0, lat, r, e, er);
    chk("pulse_lat", lat, 3);
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      dc += int'(done);
    end
    chk("pulse_extra_done", dc, 0);
    chk("pulse_ncyc", log_q.size(), 1);

    force_wait = -1;
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 2)) : 20'($urandom_range(0, 31));
      d = 16'($urandom);
      model_req(w, b, a, d, er);
      run_req(w, b, a, d, -1, lat, r, e);
      check_resp("rnd", w, lat, r, e, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
